// File: rtl/wisc_pkg.sv
// Shared WISC definitions: branch condition codes,
// flag bit positions and branch FSM state encoding.
package wisc_pkg;

    localparam logic [2:0] COND_NE     = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GE     = 3'b100;
    localparam logic [2:0] COND_LE     = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } br_state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational WISC branch condition evaluator,
// shared with the decode-stage predictor.
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       n,
    input  logic       v,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_NE:     taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_LT:     taken = n;
            COND_GE:     taken = z | (~z & ~n);
            COND_LE:     taken = n | z;
            COND_OVFL:   taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural Z/N/V flag register, branch resolution with
// ALU forwarding, and fetch redirect/squash sequencing.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_v,
    input  logic              flag_we,
    input  logic              op_arith,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              redirect_ack,
    output logic [2:0]        flags,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              squash,
    output logic [15:0]       br_taken_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    br_state_t         state_q;
    br_state_t         state_d;
    logic [2:0]        fcnt_q;
    logic [2:0]        fcnt_d;
    logic [2:0]        flags_q;
    logic [2:0]        fwd;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       cnt_q;
    logic              idle;
    logic              wr_z;
    logic              wr_nv;
    logic              cond_true;
    logic              take;

    assign idle  = (state_q == ST_IDLE);
    assign wr_z  = flag_we & ~stall & idle;
    assign wr_nv = wr_z & op_arith;

    // Per-bit bypass so a branch sees flags written in the same cycle
    always_comb begin
        fwd         = flags_q;
        fwd[FLAG_Z] = wr_z  ? alu_z : flags_q[FLAG_Z];
        fwd[FLAG_N] = wr_nv ? alu_n : flags_q[FLAG_N];
        fwd[FLAG_V] = wr_nv ? alu_v : flags_q[FLAG_V];
    end

    branch_cond_eval u_eval (
        .cond  (br_cond),
        .z     (fwd[FLAG_Z]),
        .n     (fwd[FLAG_N]),
        .v     (fwd[FLAG_V]),
        .taken (cond_true)
    );

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (br_valid && !stall && cond_true) begin
                    take    = 1'b1;
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ack) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                    fcnt_d  = 3'd0;
                end else begin
                    fcnt_d = fcnt_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fcnt_d  = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else begin
            if (wr_z) begin
                flags_q[FLAG_Z] <= alu_z;
            end
            if (wr_nv) begin
                flags_q[FLAG_N] <= alu_n;
                flags_q[FLAG_V] <= alu_v;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q  <= '0;
            cnt_q <= 16'd0;
        end else if (take) begin
            pc_q  <= br_target;
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign flags          = flags_q;
    assign redirect_valid = (state_q == ST_REDIRECT);
    assign redirect_pc    = pc_q;
    assign squash         = ~idle;
    assign br_taken_cnt   = cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit.
module tb_flag_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        alu_z;
    logic        alu_n;
    logic        alu_v;
    logic        flag_we;
    logic        op_arith;
    logic        stall;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic        redirect_ack;
    logic [2:0]  flags;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        squash;
    logic [15:0] br_taken_cnt;

    int errors = 0;
    int checks = 0;

    flag_branch_unit #(.ADDR_W(16), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_z          (alu_z),
        .alu_n          (alu_n),
        .alu_v          (alu_v),
        .flag_we        (flag_we),
        .op_arith       (op_arith),
        .stall          (stall),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_target      (br_target),
        .redirect_ack   (redirect_ack),
        .flags          (flags),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .squash         (squash),
        .br_taken_cnt   (br_taken_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  tbl [4];
    logic [2:0]  pat [4];
    logic [15:0] exp_cnt;
    logic        exp_t;

    initial begin
        rst_n = 1'b0;
        alu_z = 0; alu_n = 0; alu_v = 0;
        flag_we = 0; op_arith = 0; stall = 0;
        br_valid = 0; br_cond = 3'd0; br_target = 16'h0;
        redirect_ack = 0;
        pat[0] = 3'b000; tbl[0] = 8'h95;
        pat[1] = 3'b100; tbl[1] = 8'hB2;
        pat[2] = 3'b010; tbl[2] = 8'hA9;
        pat[3] = 3'b001; tbl[3] = 8'hD5;

        #3;
        check("rst_flags", 32'(flags), 0);
        check("rst_rv", 32'(redirect_valid), 0);
        check("rst_pc", 32'(redirect_pc), 0);
        check("rst_squash", 32'(squash), 0);
        check("rst_cnt", 32'(br_taken_cnt), 0);
        #9 rst_n = 1'b1;
        tick();

        // flag masking
        flag_we = 1; op_arith = 1;
        {alu_z, alu_n, alu_v} = 3'b011;
        tick();
        check("mask_arith", 32'(flags), 32'b011);
        op_arith = 0;
        {alu_z, alu_n, alu_v} = 3'b100;
        tick();
        check("mask_logic", 32'(flags), 32'b111);
        op_arith = 1;
        {alu_z, alu_n, alu_v} = 3'b000;
        tick();
        check("flags_clear", 32'(flags), 0);

        // forwarding
        alu_z = 1;
        br_valid = 1; br_cond = 3'b001; br_target = 16'h00A4;
        tick();
        flag_we = 0; br_valid = 0; alu_z = 0;
        check("fwd_rv", 32'(redirect_valid), 1);
        check("fwd_pc", 32'(redirect_pc), 32'h00A4);
        check("fwd_cnt", 32'(br_taken_cnt), 1);
        check("fwd_flags", 32'(flags), 32'b100);
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        check("fwd_ack_rv", 32'(redirect_valid), 0);
        check("fwd_flush1", 32'(squash), 1);
        tick();
        check("fwd_flush2", 32'(squash), 1);
        tick();
        check("fwd_idle", 32'(squash), 0);

        // handshake hold, REDIRECT/FLUSH gating
        br_valid = 1; br_cond = 3'b111; br_target = 16'h1234;
        tick();
        br_target = 16'h5555;
        flag_we = 1; op_arith = 1;
        {alu_z, alu_n, alu_v} = 3'b011;
        for (int i = 0; i < 3; i++) begin
            check("hold_rv", 32'(redirect_valid), 1);
            check("hold_pc", 32'(redirect_pc), 32'h1234);
            check("hold_squash", 32'(squash), 1);
            if (i < 2) tick();
        end
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        check("hold_ack_rv", 32'(redirect_valid), 0);
        check("hold_fl1", 32'(squash), 1);
        tick();
        check("hold_fl2", 32'(squash), 1);
        tick();
        br_valid = 0; flag_we = 0;
        check("hold_idle", 32'(squash), 0);
        check("hold_flags", 32'(flags), 32'b100);
        check("hold_cnt", 32'(br_taken_cnt), 2);
        check("hold_pc_end", 32'(redirect_pc), 32'h1234);

        // stall gating
        stall = 1; br_valid = 1; br_cond = 3'b111;
        flag_we = 1; br_target = 16'h7777;
        tick();
        stall = 0; br_valid = 0; flag_we = 0;
        check("stall_rv", 32'(redirect_valid), 0);
        check("stall_cnt", 32'(br_taken_cnt), 2);
        check("stall_flags", 32'(flags), 32'b100);

        // condition sweep
        exp_cnt = 16'd2;
        for (int p = 0; p < 4; p++) begin
            flag_we = 1; op_arith = 1;
            {alu_z, alu_n, alu_v} = pat[p];
            tick();
            flag_we = 0;
            check("sweep_flags", 32'(flags), 32'(pat[p]));
            for (int c = 0; c < 8; c++) begin
                br_valid = 1; br_cond = 3'(c);
                br_target = 16'(16'h0100 + c);
                exp_t = tbl[p][c];
                tick();
                br_valid = 0;
                check($sformatf("cond_f%0d_c%0d", p, c),
                      32'(redirect_valid), 32'(exp_t));
                if (exp_t) begin
                    exp_cnt = exp_cnt + 16'd1;
                    redirect_ack = 1;
                    tick();
                    redirect_ack = 0;
                    tick();
                    tick();
                end
            end
        end
        check("sweep_cnt", 32'(br_taken_cnt), 32'(exp_cnt));

        // counter wrap
        force dut.cnt_q = 16'hFFFF;
        tick();
        release dut.cnt_q;
        check("wrap_pre", 32'(br_taken_cnt), 32'hFFFF);
        br_valid = 1; br_cond = 3'b111; br_target = 16'hBEEF;
        tick();
        br_valid = 0;
        check("wrap_cnt", 32'(br_taken_cnt), 0);
        check("wrap_pc", 32'(redirect_pc), 32'hBEEF);

        // reset mid-flush
        redirect_ack = 1;
        tick();
        redirect_ack = 0;
        check("pre_rst_squash", 32'(squash), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_flags", 32'(flags), 0);
        check("mrst_squash", 32'(squash), 0);
        check("mrst_rv", 32'(redirect_valid), 0);
        check("mrst_pc", 32'(redirect_pc), 0);
        check("mrst_cnt", 32'(br_taken_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_squash", 32'(squash), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
